// File: rtl/axil_slave_frontend_ldmx.sv
// axil_slave_frontend_ldmx: AXI4-Lite slave front end feeding the merge stage start/ready request interface
// Ports:
//   axilClk, axilRstN               clock, asynchronous active-low reset
//   s_ar*, s_r*                     AXI-Lite read address / read data channels
//   s_aw*, s_w*, s_b*               AXI-Lite write address / write data / write response channels
//   raddr, rstart, rready, dn_r*    read request side toward the merge stage
//   waddr, wstart, bready, wdata,
//   wstrb, dn_b*                    write request side toward the merge stage
module axil_slave_frontend_ldmx #(
    parameter int TIMEOUT  = 1024,
    parameter int ADDR_LSB = 2
) (
    input  logic        axilClk,
    input  logic        axilRstN,
    input  logic [31:0] s_araddr,
    input  logic        s_arvalid,
    output logic        s_arready,
    output logic [31:0] s_rdata,
    output logic [1:0]  s_rresp,
    output logic        s_rvalid,
    input  logic        s_rready,
    input  logic [31:0] s_awaddr,
    input  logic        s_awvalid,
    output logic        s_awready,
    input  logic [31:0] s_wdata,
    input  logic [3:0]  s_wstrb,
    input  logic        s_wvalid,
    output logic        s_wready,
    output logic [1:0]  s_bresp,
    output logic        s_bvalid,
    input  logic        s_bready,
    output logic [17:0] raddr,
    output logic        rstart,
    output logic        rready,
    input  logic [31:0] dn_rdata,
    input  logic [1:0]  dn_rresp,
    input  logic        dn_rvalid,
    output logic [17:0] waddr,
    output logic        wstart,
    output logic        bready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    input  logic [1:0]  dn_bresp,
    input  logic        dn_bvalid
);
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP, R_SETTLE} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP, W_SETTLE} w_state_t;
    r_state_t      r_state, r_state_d;
    w_state_t      w_state, w_state_d;
    logic [CW-1:0] r_cnt, r_cnt_d, w_cnt, w_cnt_d;
    logic          r_drain, r_drain_d, w_drain, w_drain_d;
    logic          rvalid_d, rstart_d, bvalid_d, wstart_d;
    logic          aw_held, aw_held_d, w_held, w_held_d;
    logic [31:0]   rdata_d, wdata_d;
    logic [1:0]    rresp_d, bresp_d;
    logic [17:0]   raddr_d, waddr_d;
    logic [3:0]    wstrb_d;
    logic          unused_addr;
    assign unused_addr = ^{s_araddr, s_awaddr};
    always_comb begin
        r_state_d = r_state;
        r_cnt_d   = r_cnt;
        r_drain_d = r_drain;
        rdata_d   = s_rdata;
        rresp_d   = s_rresp;
        rvalid_d  = s_rvalid;
        raddr_d   = raddr;
        rstart_d  = 1'b0;
        rready    = 1'b0;
        case (r_state)
            R_IDLE: if (s_arvalid && s_arready) begin
                raddr_d   = s_araddr[ADDR_LSB+17:ADDR_LSB];
                rstart_d  = 1'b1;
                r_cnt_d   = '0;
                r_state_d = R_WAIT;
            end
            R_WAIT: if (dn_rvalid) begin
                rready    = 1'b1;
                rdata_d   = dn_rdata;
                rresp_d   = dn_rresp;
                rvalid_d  = 1'b1;
                r_state_d = R_RESP;
            end else if (r_cnt == CNT_MAX) begin
                rdata_d   = 32'hDEADBEEF;
                rresp_d   = 2'b10;
                rvalid_d  = 1'b1;
                r_drain_d = 1'b1;
                r_state_d = R_RESP;
            end else begin
                r_cnt_d = r_cnt + 1'b1;
            end
            R_RESP: if (s_rready) begin
                rvalid_d  = 1'b0;
                r_state_d = R_SETTLE;
            end
            R_SETTLE: if (!dn_rvalid && !r_drain) r_state_d = R_IDLE;
            default: r_state_d = R_IDLE;
        endcase
        // a timed-out request may still be answered late; swallow that answer before going idle
        if (r_drain && (r_state == R_RESP || r_state == R_SETTLE)) begin
            rready = 1'b1;
            if (dn_rvalid) r_drain_d = 1'b0;
        end
    end
    always_comb begin
        w_state_d = w_state;
        w_cnt_d   = w_cnt;
        w_drain_d = w_drain;
        aw_held_d = aw_held;
        w_held_d  = w_held;
        bresp_d   = s_bresp;
        bvalid_d  = s_bvalid;
        waddr_d   = waddr;
        wdata_d   = wdata;
        wstrb_d   = wstrb;
        wstart_d  = 1'b0;
        bready    = 1'b0;
        case (w_state)
            W_IDLE: begin
                if (s_awvalid && s_awready) begin
                    waddr_d   = s_awaddr[ADDR_LSB+17:ADDR_LSB];
                    aw_held_d = 1'b1;
                end
                if (s_wvalid && s_wready) begin
                    wdata_d  = s_wdata;
                    wstrb_d  = s_wstrb;
                    w_held_d = 1'b1;
                end
                if (aw_held_d && w_held_d) begin
                    wstart_d  = 1'b1;
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                    w_cnt_d   = '0;
                    w_state_d = W_WAIT;
                end
            end
            W_WAIT: if (dn_bvalid) begin
                bready    = 1'b1;
                bresp_d   = dn_bresp;
                bvalid_d  = 1'b1;
                w_state_d = W_RESP;
            end else if (w_cnt == CNT_MAX) begin
                bresp_d   = 2'b10;
                bvalid_d  = 1'b1;
                w_drain_d = 1'b1;
                w_state_d = W_RESP;
            end else begin
                w_cnt_d = w_cnt + 1'b1;
            end
            W_RESP: if (s_bready) begin
                bvalid_d  = 1'b0;
                w_state_d = W_SETTLE;
            end
            W_SETTLE: if (!dn_bvalid && !w_drain) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
        if (w_drain && (w_state == W_RESP || w_state == W_SETTLE)) begin
            bready = 1'b1;
            if (dn_bvalid) w_drain_d = 1'b0;
        end
    end
    // readies are registered so every output is 0 while reset is held
    always_ff @(posedge axilClk or negedge axilRstN) begin
        if (!axilRstN) begin
            r_state   <= R_IDLE;
            r_cnt     <= '0;
            r_drain   <= 1'b0;
            s_arready <= 1'b0;
            s_rdata   <= '0;
            s_rresp   <= '0;
            s_rvalid  <= 1'b0;
            raddr     <= '0;
            rstart    <= 1'b0;
        end else begin
            r_state   <= r_state_d;
            r_cnt     <= r_cnt_d;
            r_drain   <= r_drain_d;
            s_arready <= (r_state_d == R_IDLE);
            s_rdata   <= rdata_d;
            s_rresp   <= rresp_d;
            s_rvalid  <= rvalid_d;
            raddr     <= raddr_d;
            rstart    <= rstart_d;
        end
    end
    always_ff @(posedge axilClk or negedge axilRstN) begin
        if (!axilRstN) begin
            w_state   <= W_IDLE;
            w_cnt     <= '0;
            w_drain   <= 1'b0;
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            s_awready <= 1'b0;
            s_wready  <= 1'b0;
            s_bresp   <= '0;
            s_bvalid  <= 1'b0;
            waddr     <= '0;
            wdata     <= '0;
            wstrb     <= '0;
            wstart    <= 1'b0;
        end else begin
            w_state   <= w_state_d;
            w_cnt     <= w_cnt_d;
            w_drain   <= w_drain_d;
            aw_held   <= aw_held_d;
            w_held    <= w_held_d;
            s_awready <= (w_state_d == W_IDLE) && !aw_held_d;
            s_wready  <= (w_state_d == W_IDLE) && !w_held_d;
            s_bresp   <= bresp_d;
            s_bvalid  <= bvalid_d;
            waddr     <= waddr_d;
            wdata     <= wdata_d;
            wstrb     <= wstrb_d;
            wstart    <= wstart_d;
        end
    end
endmodule

// File: tb/tb_axil_slave_frontend_ldmx.sv
// tb_axil_slave_frontend_ldmx: self-checking bench for the AXI-Lite slave front end
module tb_axil_slave_frontend_ldmx;
    localparam int TO  = 16;
    localparam int LSB = 2;
    logic        axilClk = 1'b0, axilRstN = 1'b0;
    logic [31:0] s_araddr = '0, s_awaddr = '0, s_wdata = '0, dn_rdata = '0;
    logic        s_arvalid = 1'b0, s_rready = 1'b0, s_awvalid = 1'b0, s_wvalid = 1'b0, s_bready = 1'b0;
    logic [3:0]  s_wstrb = '0;
    logic [1:0]  dn_rresp = '0, dn_bresp = '0;
    logic        dn_rvalid = 1'b0, dn_bvalid = 1'b0;
    logic        s_arready, s_rvalid, s_awready, s_wready, s_bvalid, rstart, rready, wstart, bready;
    logic [31:0] s_rdata, wdata;
    logic [1:0]  s_rresp, s_bresp;
    logic [17:0] raddr, waddr;
    logic [3:0]  wstrb;
    logic [116:0] all_out;
    int n_cmp = 0, n_err = 0;
    int rstart_cnt = 0, rready_cnt = 0, wstart_cnt = 0, bready_cnt = 0;

    axil_slave_frontend_ldmx #(.TIMEOUT(TO), .ADDR_LSB(LSB)) dut (
        .axilClk(axilClk), .axilRstN(axilRstN),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .raddr(raddr), .rstart(rstart), .rready(rready),
        .dn_rdata(dn_rdata), .dn_rresp(dn_rresp), .dn_rvalid(dn_rvalid),
        .waddr(waddr), .wstart(wstart), .bready(bready), .wdata(wdata), .wstrb(wstrb),
        .dn_bresp(dn_bresp), .dn_bvalid(dn_bvalid)
    );

    assign all_out = {s_arready, s_rdata, s_rresp, s_rvalid, s_awready, s_wready, s_bresp, s_bvalid,
                      raddr, rstart, rready, waddr, wstart, bready, wdata, wstrb};

    always #5 axilClk = ~axilClk;

    always @(posedge axilClk) begin
        rstart_cnt <= rstart_cnt + int'(rstart);
        rready_cnt <= rready_cnt + int'(rready);
        wstart_cnt <= wstart_cnt + int'(wstart);
        bready_cnt <= bready_cnt + int'(bready);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [17:0] word_addr(input logic [31:0] a);
        return 18'((a / (32'd1 << LSB)) % 32'd262144);
    endfunction

    task automatic do_read(input logic [31:0] addr, input int lat, input logic [31:0] data,
                           input logic [1:0] resp, input int hold, input int rdly);
        int rs0, rr0, nv, at, exp_at;
        @(negedge axilClk);
        n_cmp++; if (s_arready !== 1'b1) begin n_err++; $display("FAIL rd_arready_idle: got %b want 1", s_arready); end
        s_araddr = addr; s_arvalid = 1'b1; rs0 = rstart_cnt; rr0 = rready_cnt;
        @(negedge axilClk);
        s_arvalid = 1'b0; s_araddr = $urandom;
        n_cmp++; if (rstart !== 1'b1 || raddr !== word_addr(addr)) begin
            n_err++; $display("FAIL rd_start: rstart=%b raddr=%h want 1 %h", rstart, raddr, word_addr(addr)); end
        n_cmp++; if (s_arready !== 1'b0) begin n_err++; $display("FAIL rd_arready_busy: got %b want 0", s_arready); end
        repeat (lat) @(negedge axilClk);
        n_cmp++; if (s_rvalid !== 1'b0) begin n_err++; $display("FAIL rd_early_rvalid: got %b want 0", s_rvalid); end
        dn_rvalid = 1'b1; dn_rdata = data; dn_rresp = resp;
        #1;
        n_cmp++; if (rready !== 1'b1) begin n_err++; $display("FAIL rd_rready: got %b want 1", rready); end
        @(negedge axilClk);
        dn_rdata = $urandom; dn_rresp = 2'($urandom);
        n_cmp++; if ({s_rvalid, s_rdata, s_rresp} !== {1'b1, data, resp}) begin
            n_err++; $display("FAIL rd_resp: got %b %h %b want 1 %h %b", s_rvalid, s_rdata, s_rresp, data, resp); end
        nv = 0; at = -1;
        for (int i = 0; i < 64; i++) begin
            if (s_arready) begin at = i; break; end
            if (s_rvalid) begin
                nv++;
                n_cmp++; if (s_rdata !== data || s_rresp !== resp) begin
                    n_err++; $display("FAIL rd_hold: got %h %b want %h %b", s_rdata, s_rresp, data, resp); end
            end
            dn_rvalid = (i < hold);
            s_rready = s_rvalid && (i >= rdly);
            @(negedge axilClk);
        end
        s_rready = 1'b0; dn_rvalid = 1'b0;
        exp_at = (rdly + 1 > hold ? rdly + 1 : hold) + 1;
        n_cmp++; if (nv !== rdly + 1) begin n_err++; $display("FAIL rd_rvalid_len: got %0d want %0d", nv, rdly + 1); end
        n_cmp++; if (at !== exp_at) begin n_err++; $display("FAIL rd_arready_return: got %0d want %0d", at, exp_at); end
        n_cmp++; if (rstart_cnt - rs0 !== 1 || rready_cnt - rr0 !== 1) begin
            n_err++; $display("FAIL rd_strobes: rstart=%0d rready=%0d want 1 1", rstart_cnt - rs0, rready_cnt - rr0); end
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int gap, input int lat, input logic [1:0] resp, input int hold, input int bdly);
        int ta, tw, tl, ws0, br0, nv, at, exp_at;
        ta = gap < 0 ? 0 : gap;
        tw = gap < 0 ? -gap : 0;
        tl = ta > tw ? ta : tw;
        ws0 = wstart_cnt; br0 = bready_cnt;
        for (int t = 0; t <= tl; t++) begin
            @(negedge axilClk);
            s_awvalid = (t == ta); s_wvalid = (t == tw);
            if (t == ta) begin
                s_awaddr = addr;
                n_cmp++; if (s_awready !== 1'b1) begin n_err++; $display("FAIL wr_awready: got %b want 1", s_awready); end
            end
            if (t == tw) begin
                s_wdata = data; s_wstrb = strb;
                n_cmp++; if (s_wready !== 1'b1) begin n_err++; $display("FAIL wr_wready: got %b want 1", s_wready); end
            end
            if (t == tw + 1 && ta > tw) begin
                n_cmp++; if ({s_awready, s_wready} !== 2'b10) begin
                    n_err++; $display("FAIL wr_w_held: aw/w ready got %b want 10", {s_awready, s_wready}); end
            end
            if (t == ta + 1 && tw > ta) begin
                n_cmp++; if ({s_awready, s_wready} !== 2'b01) begin
                    n_err++; $display("FAIL wr_aw_held: aw/w ready got %b want 01", {s_awready, s_wready}); end
            end
            n_cmp++; if (wstart !== 1'b0) begin n_err++; $display("FAIL wr_early_wstart: got %b want 0", wstart); end
        end
        @(negedge axilClk);
        s_awvalid = 1'b0; s_wvalid = 1'b0; s_awaddr = $urandom; s_wdata = $urandom; s_wstrb = 4'($urandom);
        n_cmp++; if ({wstart, waddr, wdata, wstrb} !== {1'b1, word_addr(addr), data, strb}) begin
            n_err++; $display("FAIL wr_start: got %b %h %h %h want 1 %h %h %h", wstart, waddr, wdata, wstrb, word_addr(addr), data, strb); end
        n_cmp++; if ({s_awready, s_wready} !== 2'b00) begin n_err++; $display("FAIL wr_ready_busy: got %b want 00", {s_awready, s_wready}); end
        repeat (lat) @(negedge axilClk);
        n_cmp++; if (s_bvalid !== 1'b0) begin n_err++; $display("FAIL wr_early_bvalid: got %b want 0", s_bvalid); end
        dn_bvalid = 1'b1; dn_bresp = resp;
        #1;
        n_cmp++; if (bready !== 1'b1) begin n_err++; $display("FAIL wr_bready: got %b want 1", bready); end
        @(negedge axilClk);
        dn_bresp = 2'($urandom);
        n_cmp++; if ({s_bvalid, s_bresp} !== {1'b1, resp}) begin
            n_err++; $display("FAIL wr_resp: got %b %b want 1 %b", s_bvalid, s_bresp, resp); end
        nv = 0; at = -1;
        for (int i = 0; i < 64; i++) begin
            if (s_awready) begin at = i; break; end
            if (s_bvalid) nv++;
            n_cmp++; if ({waddr, wdata, wstrb, s_bresp} !== {word_addr(addr), data, strb, resp}) begin
                n_err++; $display("FAIL wr_hold: got %h %h %h %b want %h %h %h %b", waddr, wdata, wstrb, s_bresp, word_addr(addr), data, strb, resp); end
            dn_bvalid = (i < hold);
            s_bready = s_bvalid && (i >= bdly);
            s_wdata = $urandom;
            @(negedge axilClk);
        end
        s_bready = 1'b0; dn_bvalid = 1'b0;
        exp_at = (bdly + 1 > hold ? bdly + 1 : hold) + 1;
        n_cmp++; if (nv !== bdly + 1) begin n_err++; $display("FAIL wr_bvalid_len: got %0d want %0d", nv, bdly + 1); end
        n_cmp++; if (at !== exp_at || s_wready !== 1'b1) begin
            n_err++; $display("FAIL wr_ready_return: got %0d wready=%b want %0d 1", at, s_wready, exp_at); end
        n_cmp++; if (wstart_cnt - ws0 !== 1 || bready_cnt - br0 !== 1) begin
            n_err++; $display("FAIL wr_strobes: wstart=%0d bready=%0d want 1 1", wstart_cnt - ws0, bready_cnt - br0); end
    endtask

    task automatic test_reset();
        axilRstN = 1'b0;
        repeat (2) @(negedge axilClk);
        n_cmp++; if (all_out !== '0) begin n_err++; $display("FAIL reset_outputs: got %h want 0", all_out); end
        axilRstN = 1'b1;
        @(negedge axilClk);
        n_cmp++; if ({s_arready, s_awready, s_wready} !== 3'b111) begin
            n_err++; $display("FAIL reset_ready: got %b want 111", {s_arready, s_awready, s_wready}); end
    endtask

    task automatic test_read_basic();
        do_read(32'h0000_0400, 3, 32'h1234_5678, 2'b00, 2, 0);
    endtask

    task automatic test_write_basic();
        do_write(32'h0004_4000, 32'hCAFE_F00D, 4'hF, 5, 3, 2'b00, 2, 0);
    endtask

    task automatic test_read_error();
        do_read(32'h0003_FFFC, 1, $urandom, 2'b11, 4, 0);
    endtask

    task automatic test_read_timeout();
        int rs0, rr0;
        int late = 40;
        @(negedge axilClk);
        s_araddr = 32'h0000_0800; s_arvalid = 1'b1; rs0 = rstart_cnt; rr0 = rready_cnt;
        @(negedge axilClk);
        s_arvalid = 1'b0;
        n_cmp++; if (rstart !== 1'b1) begin n_err++; $display("FAIL rto_rstart: got %b want 1", rstart); end
        for (int c = 0; c <= late + 2; c++) begin
            dn_rvalid = (c == late); dn_rdata = 32'h5555_AAAA; dn_rresp = 2'b00;
            s_rready = (c == TO);
            #1;
            if (c == TO - 1) begin
                n_cmp++; if (s_rvalid !== 1'b0) begin n_err++; $display("FAIL rto_early: got %b want 0", s_rvalid); end
            end
            if (c == TO) begin
                n_cmp++; if ({s_rvalid, s_rdata, s_rresp} !== {1'b1, 32'hDEADBEEF, 2'b10}) begin
                    n_err++; $display("FAIL rto_resp: got %b %h %b want 1 deadbeef 10", s_rvalid, s_rdata, s_rresp); end
            end
            if (c >= TO && c <= late) begin
                n_cmp++; if (rready !== 1'b1) begin n_err++; $display("FAIL rto_drain c=%0d: rready got %b want 1", c, rready); end
            end
            if (c == late + 1) begin
                n_cmp++; if ({rready, s_rvalid, s_rdata} !== {1'b0, 1'b0, 32'hDEADBEEF}) begin
                    n_err++; $display("FAIL rto_after_drain: got %b %b %h want 0 0 deadbeef", rready, s_rvalid, s_rdata); end
            end
            n_cmp++; if (s_arready !== (c == late + 2)) begin
                n_err++; $display("FAIL rto_arready c=%0d: got %b want %b", c, s_arready, c == late + 2); end
            @(negedge axilClk);
        end
        dn_rvalid = 1'b0; s_rready = 1'b0;
        n_cmp++; if (rready_cnt - rr0 !== late - TO + 1 || rstart_cnt - rs0 !== 1) begin
            n_err++; $display("FAIL rto_strobes: rready=%0d rstart=%0d want %0d 1", rready_cnt - rr0, rstart_cnt - rs0, late - TO + 1); end
    endtask

    task automatic test_write_timeout();
        int br0;
        int late = 20;
        logic [31:0] d = $urandom;
        @(negedge axilClk);
        s_awaddr = 32'h0000_0C08; s_wdata = d; s_wstrb = 4'b1001; s_awvalid = 1'b1; s_wvalid = 1'b1; br0 = bready_cnt;
        @(negedge axilClk);
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        n_cmp++; if ({wstart, waddr} !== {1'b1, word_addr(32'h0000_0C08)}) begin
            n_err++; $display("FAIL wto_start: got %b %h want 1 %h", wstart, waddr, word_addr(32'h0000_0C08)); end
        for (int c = 0; c <= late + 2; c++) begin
            dn_bvalid = (c == late); dn_bresp = 2'b01;
            s_bready = (c == TO);
            s_wdata = $urandom;
            #1;
            if (c == TO) begin
                n_cmp++; if ({s_bvalid, s_bresp} !== 3'b110) begin
                    n_err++; $display("FAIL wto_resp: got %b %b want 1 10", s_bvalid, s_bresp); end
            end
            if (c >= TO && c <= late) begin
                n_cmp++; if (bready !== 1'b1) begin n_err++; $display("FAIL wto_drain c=%0d: bready got %b want 1", c, bready); end
            end
            if (c <= late + 1) begin
                n_cmp++; if ({wdata, wstrb} !== {d, 4'b1001}) begin
                    n_err++; $display("FAIL wto_hold: got %h %h want %h 9", wdata, wstrb, d); end
            end
            n_cmp++; if ({s_awready, s_wready} !== {2{c == late + 2}}) begin
                n_err++; $display("FAIL wto_ready c=%0d: got %b", c, {s_awready, s_wready}); end
            @(negedge axilClk);
        end
        dn_bvalid = 1'b0; s_bready = 1'b0;
        n_cmp++; if (bready_cnt - br0 !== late - TO + 1) begin
            n_err++; $display("FAIL wto_strobes: bready=%0d want %0d", bready_cnt - br0, late - TO + 1); end
    endtask

    task automatic test_concurrent();
        fork
            do_read(32'h1234_5678, 2, 32'hA5A5_0001, 2'b00, 1, 10);
            do_write(32'h8765_4320, 32'h0BAD_F00D, 4'b0101, 0, 2, 2'b01, 1, 10);
        join
    endtask

    task automatic test_random();
        for (int k = 0; k < 8; k++) begin
            fork
                do_read($urandom, int'($urandom_range(0, 10)), $urandom, 2'($urandom),
                        int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
                do_write($urandom, $urandom, 4'($urandom), int'($urandom_range(0, 6)) - 3,
                         int'($urandom_range(0, 10)), 2'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            join
        end
    endtask

    task automatic test_reset_mid();
        @(negedge axilClk);
        s_araddr = 32'h0000_1000; s_arvalid = 1'b1;
        @(negedge axilClk);
        s_arvalid = 1'b0;
        repeat (3) @(negedge axilClk);
        n_cmp++; if (s_arready !== 1'b0) begin n_err++; $display("FAIL rmid_busy: arready got %b want 0", s_arready); end
        #2 axilRstN = 1'b0;
        #1;
        n_cmp++; if (all_out !== '0) begin n_err++; $display("FAIL rmid_async: got %h want 0", all_out); end
        @(negedge axilClk);
        axilRstN = 1'b1;
        @(negedge axilClk);
        n_cmp++; if (s_arready !== 1'b1) begin n_err++; $display("FAIL rmid_arready: got %b want 1", s_arready); end
        do_read(32'h0002_0004, 2, $urandom, 2'b00, 0, 1);
    endtask

    initial begin
        test_reset();
        test_read_basic();
        test_write_basic();
        test_read_error();
        test_read_timeout();
        test_write_timeout();
        test_concurrent();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/axil_slave_frontend_ldmx.md
Name: axil_slave_frontend_ldmx

Overview:
AXI4-Lite slave front end that terminates the five AXI-Lite channels from the interconnect and drives the merge/decoder stage's simple start/ready request interface (raddr/rstart/rready, waddr/wstart/bready). It converts byte addresses to 18-bit word addresses and holds write data and strobes stable for the clients. It serialises one read and one write in flight, independently of each other. A per-transaction timeout guarantees the AXI master always gets a response even if no client answers.

Parameters:
TIMEOUT, 1024, cycles waiting for a downstream response before answering SLVERR (minimum 4).
ADDR_LSB, 2, byte-address bit mapped to word-address bit 0.

Ports:
axilClk  in  1  AXI-Lite clock; all logic on its rising edge.
axilRstN  in  1  asynchronous active-low reset.
s_araddr  in  32  read byte address.
s_arvalid  in  1  read address valid.
s_arready  out  1  read address ready.
s_rdata  out  32  read data.
s_rresp  out  2  read response.
s_rvalid  out  1  read data valid.
s_rready  in  1  read data ready.
s_awaddr  in  32  write byte address.
s_awvalid  in  1  write address valid.
s_awready  out  1  write address ready.
s_wdata  in  32  write data.
s_wstrb  in  4  write byte strobes.
s_wvalid  in  1  write data valid.
s_wready  out  1  write data ready.
s_bresp  out  2  write response.
s_bvalid  out  1  write response valid.
s_bready  in  1  write response ready.
raddr  out  18  word read address to the merge stage.
rstart  out  1  one-cycle read start pulse.
rready  out  1  read-response acknowledge to the merge stage.
dn_rdata  in  32  merge read data.
dn_rresp  in  2  merge read response.
dn_rvalid  in  1  merge read valid.
waddr  out  18  word write address to the merge stage.
wstart  out  1  one-cycle write start pulse.
bready  out  1  write-response acknowledge to the merge stage.
wdata  out  32  write data, held from wstart through completion.
wstrb  out  4  write strobes, held like wdata.
dn_bresp  in  2  merge write response.
dn_bvalid  in  1  merge write response valid.

Behaviour:
- Reset (axilRstN=0, asynchronous): all outputs 0; both FSMs go to IDLE; timeout counters cleared.
- Address mapping: raddr = s_araddr[ADDR_LSB+17:ADDR_LSB], and likewise for waddr. Upper bits are ignored.
- Read FSM states: R_IDLE, R_WAIT, R_RESP, R_SETTLE.
  - R_IDLE: s_arready=1. On s_arvalid, latch raddr, pulse rstart for exactly 1 cycle (the cycle after the handshake), clear the counter, go to R_WAIT.
  - R_WAIT: s_arready=0. On dn_rvalid=1, capture dn_rdata/dn_rresp, drive rready=1 for that single cycle, go to R_RESP.
  - R_WAIT timeout: if the counter reaches TIMEOUT-1 first, load s_rdata=32'hDEADBEEF and s_rresp=2'b10, and go to R_RESP with a pending-drain flag set.
  - R_RESP: s_rvalid=1 with data held. On s_rready, drop s_rvalid and go to R_SETTLE.
  - R_SETTLE: wait until dn_rvalid=0, then go to R_IDLE. The merge stage's rvalid lags its strobe clear by about 2 cycles, so this prevents a stale re-capture.
  - Pending drain: while the flag is set, rready=1 is held continuously in R_RESP and R_SETTLE until the first dn_rvalid is consumed, then the flag clears. R_IDLE is not re-entered while the flag is set.
- Write FSM states: W_IDLE, W_WAIT, W_RESP, W_SETTLE.
  - W_IDLE: s_awready and s_wready each deassert individually once their own beat is captured. AW and W may arrive in either order or together.
  - Once both are held: latch waddr/wdata/wstrb, pulse wstart for 1 cycle, go to W_WAIT.
  - W_WAIT, W_RESP, W_SETTLE mirror the read FSM, using dn_bvalid/dn_bresp/bready and s_bvalid/s_bresp.
  - Timeout in W_WAIT gives s_bresp=2'b10.
  - wdata/wstrb stay constant from wstart until the return to W_IDLE.
- The read and write FSMs are fully independent; simultaneous AR and AW are both accepted in the same cycle.
- Latency, no stalls:
  - rstart is asserted 1 cycle after the AR handshake.
  - s_rvalid is asserted 1 cycle after dn_rvalid.
  - wstart is asserted 1 cycle after the later of the AW/W handshakes.
- dn_rvalid/dn_bvalid arriving outside a WAIT state or drain are ignored.
- Counters saturate at TIMEOUT-1; width is $clog2(TIMEOUT).

Test Plan:
1. Read 0x400 → raddr=18'h00100, rstart high 1 cycle; merge returns dn_rdata=32'h12345678, rresp 0 after 3 cycles → s_rdata=32'h12345678, s_rresp=0, rready pulsed once.
2. W beat (wdata=32'hCAFEF00D, wstrb=4'hF) 5 cycles before AW 0x44000 → wstart exactly once, waddr=18'h11000, wdata held until s_bvalid/s_bready; s_bresp=0.
3. Read of unmapped 0x3FFFC with merge returning dn_rresp=2'b11 → s_rresp=2'b11; next AR is not accepted until dn_rvalid=0.
4. TIMEOUT=16, no merge response → s_rvalid at cycle 16 after rstart with s_rresp=2'b10; late dn_rvalid at cycle 40 is drained via rready, and s_arready returns only after that.
5. AR and AW+W in the same cycle with s_rready/s_bready held low for 10 cycles → both responses held stable, no extra strobes; both complete after the ready signals assert.
6. axilRstN asserted mid-R_WAIT → all outputs 0 immediately (asynchronous); after release s_arready=1 and a new read completes normally.
